// File: rtl/life_pkg.sv
// Shared types and sizes for the 8x8 Life generation controller.
package life_pkg;

  localparam int GRID_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} seq_state_t;
  typedef enum logic [1:0] {NONE, EXTINCT, STABLE, LIMIT} halt_cause_t;

endpackage

// File: rtl/life_tick_div.sv
// Generation-rate divider: tick is high on the last count of each TICK_DIV period.
module life_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Life generation controller: owns the grid, schedules commits, detects halts.
// Optional period-2 oscillator detection when LIFE_PERIOD2_DETECT_EN is defined.
module life_sequencer
  import life_pkg::*;
#(
  parameter int GEN_W    = 16,
  parameter int TICK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              randomize,
  input  logic              run,
  input  logic              step,
  input  logic [GEN_W-1:0]  gen_limit,
  input  logic [GRID_W-1:0] seed,
  input  logic [GRID_W-1:0] rand_in,
  input  logic [GRID_W-1:0] next_grid,
  output logic [GRID_W-1:0] grid,
  output logic [GEN_W-1:0]  gen_count,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output seq_state_t        state_dbg
);

  seq_state_t        state_q, state_d;
  logic [GRID_W-1:0] grid_q, grid_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  halt_cause_t       cause_q, cause_d;
  logic              busy_q, halted_q;
  logic              commit, tick, div_en, osc2;
  logic              reseed;
  logic [GEN_W:0]    gen_plus1;

  assign reseed    = load || randomize;
  assign div_en    = (state_q == RUN) && run && !reseed;
  assign gen_plus1 = {1'b0, gen_q} + (GEN_W+1)'(1);

  life_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (!div_en),
    .en    (div_en),
    .tick  (tick)
  );

`ifdef LIFE_PERIOD2_DETECT_EN
  logic [GRID_W-1:0] prev_q;

  // Grid as it was before the most recent commit, for period-2 matching.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else if (reseed) begin
      prev_q <= '0;
    end else if (commit) begin
      prev_q <= grid_q;
    end
  end

  assign osc2 = (next_grid == prev_q) && (gen_q != '0);
`else
  assign osc2 = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    gen_d   = gen_q;
    cause_d = cause_q;
    commit  = 1'b0;
    if (reseed) begin
      grid_d  = load ? seed : rand_in;
      gen_d   = '0;
      cause_d = NONE;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (run)       state_d = RUN;
          else if (step) state_d = STEP;
        end
        RUN: begin
          if (!run)      state_d = IDLE;
          else if (tick) commit  = 1'b1;
        end
        STEP:    commit = 1'b1;
        default: ;
      endcase
    end
    if (commit) begin
      grid_d  = next_grid;
      gen_d   = (gen_q == '1) ? gen_q : gen_plus1[GEN_W-1:0];
      state_d = (state_q == STEP) ? IDLE : RUN;
      // Halt causes ranked extinct > stable > limit.
      if (next_grid == '0) begin
        cause_d = EXTINCT;
        state_d = HALT;
      end else if ((next_grid == grid_q) || osc2) begin
        cause_d = STABLE;
        state_d = HALT;
      end else if ((gen_limit != '0) && (gen_plus1 >= {1'b0, gen_limit})) begin
        cause_d = LIMIT;
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grid_q   <= '0;
      gen_q    <= '0;
      cause_q  <= NONE;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      gen_q    <= gen_d;
      cause_q  <= cause_d;
      busy_q   <= (state_d == RUN) || (state_d == STEP);
      halted_q <= (state_d == HALT);
    end
  end

  assign grid       = grid_q;
  assign gen_count  = gen_q;
  assign halt_cause = cause_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a bounded-edge Life model on next_grid.
module tb_life_sequencer;
  import life_pkg::*;

  localparam int GEN_W = 16;
  localparam int TD    = 4;
  localparam logic [63:0] BLINK_H = 64'h0000_0E00;
  localparam logic [63:0] BLINK_V = 64'h0004_0404;
  localparam logic [63:0] BLOCK   = 64'h0000_0303;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0, randomize = 1'b0, run = 1'b0, step = 1'b0;
  logic [GEN_W-1:0]  gen_limit = '0;
  logic [63:0]       seed = '0, rand_in = '0, next_grid;
  logic [63:0]       grid;
  logic [GEN_W-1:0]  gen_count;
  logic              busy, halted;
  logic [1:0]        halt_cause;
  seq_state_t        state_dbg;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  life_sequencer #(.GEN_W(GEN_W), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .randomize  (randomize),
    .run        (run),
    .step       (step),
    .gen_limit  (gen_limit),
    .seed       (seed),
    .rand_in    (rand_in),
    .next_grid  (next_grid),
    .grid       (grid),
    .gen_count  (gen_count),
    .busy       (busy),
    .halted     (halted),
    .halt_cause (halt_cause),
    .state_dbg  (state_dbg)
  );

  // Reference next-state datapath; cells beyond the 8x8 edge count as dead.
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r+dr >= 0) && (r+dr < 8) && (c+dc >= 0) && (c+dc < 8))
              cnt += int'(g[(r+dr)*8 + (c+dc)]);
          end
        end
        n[r*8+c] = (cnt == 3) || (g[r*8+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  assign next_grid = life_next(grid);

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [63:0] pat, input logic [GEN_W-1:0] lim);
    seed      = pat;
    gen_limit = lim;
    load      = 1'b1;
    tick(1);
    load      = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    do_load(BLINK_H, '0);
    run = 1'b1;
    tick(1 + TD + 2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (grid !== 64'h0 || gen_count !== '0 || halted !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: grid=%h gen=%0d halted=%b busy=%b want 0/0/0/0", grid, gen_count, halted, busy);
    end
    checks++;
    if (state_dbg !== IDLE || halt_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: state=%0d cause=%b want IDLE/00", state_dbg, halt_cause);
    end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_step;
    do_load(BLINK_H, '0);
    checks++;
    if (grid !== BLINK_H || gen_count !== '0) begin
      errors++;
      $display("FAIL load_seed: grid=%h gen=%0d want %h/0", grid, gen_count, BLINK_H);
    end
    step = 1'b1;
    tick(1);
    step = 1'b0;
    checks++;
    if (state_dbg !== STEP || busy !== 1'b1 || grid !== BLINK_H) begin
      errors++;
      $display("FAIL step_enter: state=%0d busy=%b grid=%h want STEP/1/%h", state_dbg, busy, grid, BLINK_H);
    end
    tick(1);
    checks++;
    if (grid !== BLINK_V || gen_count !== 16'd1 || state_dbg !== IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL step_commit: grid=%h gen=%0d state=%0d busy=%b want %h/1/IDLE/0", grid, gen_count, state_dbg, busy, BLINK_V);
    end
  endtask

  task automatic test_run_exit;
    do_load(BLINK_H, '0);
    run  = 1'b1;
    step = 1'b1;
    tick(1);
    step = 1'b0;
    checks++;
    if (state_dbg !== RUN || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_over_step: state=%0d busy=%b want RUN/1", state_dbg, busy);
    end
    tick(2);
    run = 1'b0;
    tick(1);
    checks++;
    if (state_dbg !== IDLE || gen_count !== '0 || grid !== BLINK_H) begin
      errors++;
      $display("FAIL run_exit: state=%0d gen=%0d grid=%h want IDLE/0/%h", state_dbg, gen_count, grid, BLINK_H);
    end
    run = 1'b1;
    tick(1 + TD - 1);
    checks++;
    if (gen_count !== '0) begin
      errors++;
      $display("FAIL partial_tick_discard: gen=%0d want 0", gen_count);
    end
    tick(1);
    checks++;
    if (gen_count !== 16'd1 || grid !== BLINK_V) begin
      errors++;
      $display("FAIL run_first_commit: gen=%0d grid=%h want 1/%h", gen_count, grid, BLINK_V);
    end
    run = 1'b0;
    tick(1);
  endtask

  task automatic test_limit;
    do_load(BLINK_H, 16'd3);
    run = 1'b1;
    tick(1 + 2 * TD);
    checks++;
    if (gen_count !== 16'd2 || grid !== BLINK_H || halted !== 1'b0) begin
      errors++;
      $display("FAIL limit_gen2: gen=%0d grid=%h halted=%b want 2/%h/0", gen_count, grid, halted, BLINK_H);
    end
    tick(TD);
    checks++;
    if (gen_count !== 16'd3 || grid !== BLINK_V || halted !== 1'b1 || halt_cause !== 2'b11 || busy !== 1'b0) begin
      errors++;
      $display("FAIL limit_halt: gen=%0d grid=%h halted=%b cause=%b busy=%b want 3/%h/1/11/0", gen_count, grid, halted, halt_cause, busy, BLINK_V);
    end
    tick(2 * TD);
    checks++;
    if (gen_count !== 16'd3 || grid !== BLINK_V || state_dbg !== HALT) begin
      errors++;
      $display("FAIL limit_frozen: gen=%0d grid=%h state=%0d want 3/%h/HALT", gen_count, grid, state_dbg, BLINK_V);
    end
    run = 1'b0;
  endtask

  task automatic test_stable;
    do_load(BLOCK, '0);
    run = 1'b1;
    tick(1 + TD);
    checks++;
    if (gen_count !== 16'd1 || halt_cause !== 2'b10 || halted !== 1'b1 || grid !== BLOCK) begin
      errors++;
      $display("FAIL stable_halt: gen=%0d cause=%b halted=%b grid=%h want 1/10/1/%h", gen_count, halt_cause, halted, grid, BLOCK);
    end
    run  = 1'b0;
    step = 1'b1;
    tick(3);
    run  = 1'b1;
    tick(TD + 1);
    step = 1'b0;
    run  = 1'b0;
    checks++;
    if (gen_count !== 16'd1 || state_dbg !== HALT || grid !== BLOCK || halt_cause !== 2'b10) begin
      errors++;
      $display("FAIL halt_ignores_step_run: gen=%0d state=%0d grid=%h cause=%b want 1/HALT/%h/10", gen_count, state_dbg, grid, halt_cause, BLOCK);
    end
  endtask

  task automatic test_extinct_and_priority;
    do_load(64'h1, '0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(1);
    checks++;
    if (grid !== 64'h0 || halt_cause !== 2'b01 || halted !== 1'b1 || gen_count !== 16'd1) begin
      errors++;
      $display("FAIL extinct: grid=%h cause=%b halted=%b gen=%0d want 0/01/1/1", grid, halt_cause, halted, gen_count);
    end
    seed      = 64'hDEAD_BEEF_0123_4567;
    rand_in   = 64'h1357_9BDF_2468_ACE0;
    load      = 1'b1;
    randomize = 1'b1;
    tick(1);
    load      = 1'b0;
    randomize = 1'b0;
    checks++;
    if (grid !== 64'hDEAD_BEEF_0123_4567 || halt_cause !== 2'b00 || state_dbg !== IDLE || halted !== 1'b0 || gen_count !== '0) begin
      errors++;
      $display("FAIL load_beats_random: grid=%h cause=%b state=%0d halted=%b gen=%0d", grid, halt_cause, state_dbg, halted, gen_count);
    end
    randomize = 1'b1;
    tick(1);
    randomize = 1'b0;
    checks++;
    if (grid !== 64'h1357_9BDF_2468_ACE0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL randomize: grid=%h state=%0d want 1357_9bdf_2468_ace0/IDLE", grid, state_dbg);
    end
    do_load(64'h0, '0);
    tick(3);
    checks++;
    if (halted !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL empty_idle_no_halt: halted=%b state=%0d want 0/IDLE", halted, state_dbg);
    end
  endtask

  task automatic test_oscillator;
    do_load(BLINK_H, '0);
    run = 1'b1;
`ifdef LIFE_PERIOD2_DETECT_EN
    tick(1 + 2 * TD);
    checks++;
    if (halted !== 1'b1 || halt_cause !== 2'b10 || gen_count !== 16'd2 || grid !== BLINK_H) begin
      errors++;
      $display("FAIL period2_halt: halted=%b cause=%b gen=%0d grid=%h want 1/10/2/%h", halted, halt_cause, gen_count, grid, BLINK_H);
    end
`else
    tick(1 + 100 * TD);
    checks++;
    if (halted !== 1'b0 || gen_count !== 16'd100 || grid !== BLINK_H || state_dbg !== RUN) begin
      errors++;
      $display("FAIL oscillator_runs: halted=%b gen=%0d grid=%h state=%0d want 0/100/%h/RUN", halted, gen_count, grid, state_dbg, BLINK_H);
    end
`endif
    run = 1'b0;
    tick(1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tick(2);
    checks++;
    if (grid !== 64'h0 || gen_count !== '0 || busy !== 1'b0 || halted !== 1'b0 || halt_cause !== 2'b00) begin
      errors++;
      $display("FAIL power_on_reset: grid=%h gen=%0d busy=%b halted=%b cause=%b", grid, gen_count, busy, halted, halt_cause);
    end
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    test_reset;
    test_step;
    test_run_exit;
    test_limit;
    test_stable;
    test_extinct_and_priority;
    test_oscillator;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
